// File: rtl/pipe_stage_chain_pkg.sv
// Shared types for the handshaked register chain: a valid/ready
// bundle with its transfer helper, and the occupancy width function.
package pipe_stage_chain_pkg;

  typedef struct packed {
    logic valid;
    logic ready;
  } hs_t;

  function automatic logic hs_fire(hs_t h);
    return h.valid & h.ready;
  endfunction

  function automatic int OCC_W(int depth, int skid);
    return $clog2(depth + skid + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_chain_skid.sv
// pipe_skid_entry: one-entry skid register (valid + payload).
// Ports: clk, rst (sync, high), clear_i (flush), set_i (capture
// data_i), take_i (drained downstream), valid_o, data_o.
module pipe_skid_entry #(
  parameter int WIDTH         = 32,
  parameter bit CLEAR_PAYLOAD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             set_i,
  input  logic             take_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // set and take never coincide: set needs an empty entry,
  // take needs a full one.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = 1'b0;
      if (CLEAR_PAYLOAD) data_d = '0;
    end else if (set_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (take_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-slot valid/ready register chain with
// collapsing bubbles, flush, optional skid entry and occupancy count.
// Ports: clk, rst (sync, high); in_valid/in_ready/in_data upstream;
// out_valid/out_ready/out_data downstream; flush; occupancy.
module pipe_stage_chain
  import pipe_stage_chain_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 1,
  parameter bit SKID          = 1'b0,
  parameter bit CLEAR_PAYLOAD = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [WIDTH-1:0]                   in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WIDTH-1:0]                   out_data,
  input  logic                               flush,
  output logic [OCC_W(DEPTH,int'(SKID))-1:0] occupancy
);

  localparam int OW = OCC_W(DEPTH, int'(SKID));

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] ld;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d_q [DEPTH];

  logic             src_v;
  logic [WIDTH-1:0] src_d;

  hs_t  in_hs, out_hs;
  logic in_fire, out_fire;

  logic [OW-1:0] occ_q, occ_d;

  // Walk from the output back: a slot loads when it is empty or
  // its occupant moves on, so bubbles never block upstream.
  always_comb begin
    logic down;
    ld   = '0;
    adv  = '0;
    down = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i] = v_q[i] & down;
      ld[i]  = ~v_q[i] | adv[i];
      down   = ld[i];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic             slot_v_q, slot_v_d, up_v;
    logic [WIDTH-1:0] slot_d_q, slot_d_d, up_d;

    if (i == 0) begin : g_head
      assign up_v = src_v;
      assign up_d = src_d;
    end else begin : g_body
      assign up_v = v_q[i-1];
      assign up_d = d_q[i-1];
    end

    // Payload only moves with valid data; an emptied slot keeps
    // its last word so out_data does not toggle needlessly.
    always_comb begin
      slot_v_d = slot_v_q;
      slot_d_d = slot_d_q;
      if (ld[i]) begin
        slot_v_d = up_v;
        if (up_v) slot_d_d = up_d;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        slot_v_q <= 1'b0;
        slot_d_q <= '0;
      end else if (flush) begin
        slot_v_q <= 1'b0;
        if (CLEAR_PAYLOAD) slot_d_q <= '0;
      end else begin
        slot_v_q <= slot_v_d;
        slot_d_q <= slot_d_d;
      end
    end

    assign v_q[i] = slot_v_q;
    assign d_q[i] = slot_d_q;
  end

  if (SKID) begin : g_skid
    logic             skid_v;
    logic [WIDTH-1:0] skid_d;

    pipe_skid_entry #(
      .WIDTH         (WIDTH),
      .CLEAR_PAYLOAD (CLEAR_PAYLOAD)
    ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .clear_i (flush),
      .set_i   (in_fire & ~ld[0]),
      .take_i  (skid_v & ld[0]),
      .data_i  (in_data),
      .valid_o (skid_v),
      .data_o  (skid_d)
    );

    // A held skid word always goes first, preserving order.
    assign in_ready = ~skid_v;
    assign src_v    = skid_v | in_valid;
    assign src_d    = skid_v ? skid_d : in_data;
  end else begin : g_noskid
    assign in_ready = ld[0];
    assign src_v    = in_valid;
    assign src_d    = in_data;
  end

  assign in_hs    = '{valid: in_valid, ready: in_ready};
  assign out_hs   = '{valid: out_valid, ready: out_ready};
  assign in_fire  = hs_fire(in_hs);
  assign out_fire = hs_fire(out_hs);

  always_comb begin
    occ_d = occ_q;
    if (in_fire & ~out_fire) occ_d = occ_q + OW'(1);
    else if (out_fire & ~in_fire) occ_d = occ_q - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else if (flush) occ_q <= '0;
    else occ_q <= occ_d;
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench: four chain configurations, each checked every cycle against
// a position-queue model, plus directed literal checks per scenario.
module tb_pipe_stage_chain;
  import pipe_stage_chain_pkg::*;

  function automatic int dep_of(int g);
    case (g)
      0: return 3;
      1: return 2;
      2: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit skd_of(int g);
    return (g >= 2);
  endfunction

  logic       clk;
  logic       iv [4];
  logic       ordy [4];
  logic       fl [4];
  logic       rs [4];
  logic [7:0] id [4];
  logic       ir [4];
  logic       ov [4];
  logic [7:0] od [4];
  logic [3:0] occ [4];

  int n_chk;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int D = dep_of(g);
    localparam bit S = skd_of(g);
    logic [OCC_W(D, int'(S))-1:0] occ_w;

    pipe_stage_chain #(
      .WIDTH         (8),
      .DEPTH         (D),
      .SKID          (S),
      .CLEAR_PAYLOAD (1'b1)
    ) dut (
      .clk       (clk),
      .rst       (rs[g]),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_data   (id[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_data  (od[g]),
      .flush     (fl[g]),
      .occupancy (occ_w)
    );

    assign occ[g] = 4'(occ_w);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Model: per instance, items oldest-first with their slot position,
  // plus an optional skid item.
  int         mpos [4][8];
  logic [7:0] mdat [4][8];
  int         mcnt [4];
  bit         mskv [4];
  logic [7:0] mskd [4];

  initial begin
    int         np [8];
    logic [7:0] nd [8];
    int         nc, bound, d, p;
    bit         s, ofire, room, pr, ev;
    for (int g = 0; g < 4; g++) begin
      mcnt[g] = 0;
      mskv[g] = 1'b0;
    end
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        d = dep_of(g);
        s = skd_of(g);
        ev = (mcnt[g] > 0) && (mpos[g][0] == d - 1);
        ofire = ev && ordy[g];
        nc = 0;
        bound = d;
        for (int k = 0; k < mcnt[g]; k++) begin
          if (k == 0 && ofire) continue;
          p = mpos[g][k];
          np[nc] = (p + 1 < bound - 1) ? p + 1 : bound - 1;
          nd[nc] = mdat[g][k];
          bound = np[nc];
          nc++;
        end
        room = (nc == 0) || (np[nc-1] >= 1);
        pr = s ? !mskv[g] : room;
        chk($sformatf("i%0d in_ready", g), 32'(ir[g]), 32'(pr));
        chk($sformatf("i%0d out_valid", g), 32'(ov[g]), 32'(ev));
        if (ev)
          chk($sformatf("i%0d out_data", g), 32'(od[g]),
              32'(mdat[g][0]));
        chk($sformatf("i%0d occupancy", g), 32'(occ[g]),
            32'(mcnt[g] + int'(mskv[g])));
        if (rs[g] || fl[g]) begin
          mcnt[g] = 0;
          mskv[g] = 1'b0;
        end else begin
          if (mskv[g]) begin
            if (room) begin
              np[nc] = 0;
              nd[nc] = mskd[g];
              nc++;
              mskv[g] = 1'b0;
            end
          end else if (iv[g]) begin
            if (room) begin
              np[nc] = 0;
              nd[nc] = id[g];
              nc++;
            end else if (s) begin
              mskv[g] = 1'b1;
              mskd[g] = id[g];
            end
          end
          mcnt[g] = nc;
          for (int k = 0; k < nc; k++) begin
            mpos[g][k] = np[k];
            mdat[g][k] = nd[k];
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int g = 0; g < 4; g++) begin
      iv[g] = 1'b0;
      id[g] = 8'h00;
      ordy[g] = 1'b1;
      fl[g] = 1'b0;
      rs[g] = 1'b1;
    end
    iv[0] = 1'b1;
    id[0] = 8'hAA;

    // Reset held two edges with input offered on instance 0
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst i%0d out_valid", g), 32'(ov[g]), 0);
      chk($sformatf("rst i%0d out_data", g), 32'(od[g]), 0);
      chk($sformatf("rst i%0d occupancy", g), 32'(occ[g]), 0);
      chk($sformatf("rst i%0d in_ready", g), 32'(ir[g]), 1);
    end
    tick();
    for (int g = 0; g < 4; g++) rs[g] = 1'b0;
    tick();
    iv[0] = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      chk($sformatf("lat edge%0d out_valid", e), 32'(ov[0]),
          32'(e == 3));
      if (e == 3) chk("lat out_data", 32'(od[0]), 32'hAA);
      tick();
    end
    tick();

    // Streaming, DEPTH=2
    for (int i = 1; i <= 10; i++) begin
      iv[1] = 1'b1;
      id[1] = 8'(i);
      @(negedge clk);
      if (i >= 3) begin
        chk($sformatf("stream %0d out_data", i), 32'(od[1]),
            32'(i - 2));
        chk($sformatf("stream %0d occupancy", i), 32'(occ[1]), 2);
      end
      tick();
    end
    iv[1] = 1'b0;
    repeat (3) tick();

    // Backpressure and bubble collapse, DEPTH=3
    ordy[0] = 1'b0;
    iv[0] = 1'b1; id[0] = 8'hA1; tick();
    iv[0] = 1'b0; tick();
    iv[0] = 1'b1; id[0] = 8'hB2; tick();
    iv[0] = 1'b0; tick();
    iv[0] = 1'b1; id[0] = 8'hC3;
    @(negedge clk);
    chk("bp occupancy", 32'(occ[0]), 2);
    chk("bp in_ready", 32'(ir[0]), 1);
    tick();
    id[0] = 8'hD4;
    @(negedge clk);
    chk("bp full in_ready", 32'(ir[0]), 0);
    chk("bp full occupancy", 32'(occ[0]), 3);
    chk("bp head", 32'(od[0]), 32'hA1);
    tick();
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("bp pass-through in_ready", 32'(ir[0]), 1);
    tick();
    iv[0] = 1'b0;
    @(negedge clk); chk("bp out B", 32'(od[0]), 32'hB2); tick();
    @(negedge clk); chk("bp out C", 32'(od[0]), 32'hC3); tick();
    @(negedge clk); chk("bp out D", 32'(od[0]), 32'hD4); tick();
    tick();

    // Skid, DEPTH=2 SKID=1
    iv[2] = 1'b1; id[2] = 8'h11; tick();
    id[2] = 8'h12; tick();
    id[2] = 8'h13; tick();
    id[2] = 8'h5A; ordy[2] = 1'b0;
    @(negedge clk);
    chk("skid pre in_ready", 32'(ir[2]), 1);
    tick();
    iv[2] = 1'b0;
    @(negedge clk);
    chk("skid in_ready", 32'(ir[2]), 0);
    chk("skid occupancy", 32'(occ[2]), 3);
    chk("skid head", 32'(od[2]), 32'h12);
    tick();
    ordy[2] = 1'b1;
    @(negedge clk);
    chk("skid held in_ready", 32'(ir[2]), 0);
    tick();
    @(negedge clk);
    chk("skid drain data", 32'(od[2]), 32'h13);
    chk("skid drain occupancy", 32'(occ[2]), 2);
    chk("skid drain in_ready", 32'(ir[2]), 1);
    tick();
    @(negedge clk); chk("skid X out", 32'(od[2]), 32'h5A); tick();
    @(negedge clk); chk("skid empty", 32'(ov[2]), 0); tick();

    // Flush, DEPTH=3 SKID=1, full plus skid
    ordy[3] = 1'b0;
    iv[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      id[3] = 8'(8'h21 + i);
      tick();
    end
    iv[3] = 1'b0;
    @(negedge clk);
    chk("fl full occupancy", 32'(occ[3]), 4);
    chk("fl full in_ready", 32'(ir[3]), 0);
    tick();
    fl[3] = 1'b1; ordy[3] = 1'b1; iv[3] = 1'b1; id[3] = 8'h77;
    @(negedge clk);
    chk("fl head valid", 32'(ov[3]), 1);
    chk("fl head data", 32'(od[3]), 32'h21);
    tick();
    fl[3] = 1'b0; iv[3] = 1'b0;
    @(negedge clk);
    chk("fl out_valid", 32'(ov[3]), 0);
    chk("fl occupancy", 32'(occ[3]), 0);
    chk("fl in_ready", 32'(ir[3]), 1);
    chk("fl out_data", 32'(od[3]), 0);
    repeat (4) tick();
    @(negedge clk);
    chk("fl no Y", 32'(ov[3]), 0);
    tick();

    // Reset together with flush mid-stream, DEPTH=2 SKID=1
    ordy[2] = 1'b0;
    iv[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id[2] = 8'(8'h31 + i);
      tick();
    end
    iv[2] = 1'b0;
    @(negedge clk);
    chk("rf occupancy before", 32'(occ[2]), 3);
    tick();
    rs[2] = 1'b1; fl[2] = 1'b1;
    tick();
    rs[2] = 1'b0; fl[2] = 1'b0; ordy[2] = 1'b1;
    @(negedge clk);
    chk("rf out_valid", 32'(ov[2]), 0);
    chk("rf out_data", 32'(od[2]), 0);
    chk("rf occupancy", 32'(occ[2]), 0);
    chk("rf in_ready", 32'(ir[2]), 1);
    repeat (3) tick();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised, handshaked pipeline register chain that succeeds the fixed-field stage registers (stall `en`, flush `clear`) used between core pipeline stages. It carries an opaque WIDTH-bit payload through DEPTH register slots with per-slot valid bits and ready/valid flow control. Bubbles collapse, and an optional skid entry registers the upstream ready. It sits between any two core stages or units that need stall and flush decoupling.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- DEPTH, 1, number of register slots (≥1)
- SKID, 0, 1 adds one skid entry so that `in_ready` is a pure register output
- CLEAR_PAYLOAD, 1, 1 zeroes a slot's payload whenever its valid bit is cleared by reset or flush; 0 holds stale payload
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  upstream offers `in_data`
- in_ready  output  1  chain accepts this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  slot DEPTH-1 holds valid data
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  payload of slot DEPTH-1
- flush  input  1  discard all contents (pipeline clear)
- occupancy  output  $clog2(DEPTH+SKID+1)  count of valid entries, slots plus skid

## Operation
- Slots are indexed 0 (input side) to DEPTH-1 (output). Each slot has `v[i]` and `d[i]`.
- The advance chain is computed from the output backward:
  - `adv[DEPTH-1] = v[DEPTH-1] & out_ready`
  - slot i loads when `!v[i] | adv[i]`
  - slot i passes its data to slot i+1 when `v[i]` and slot i+1 loads
- Bubbles collapse: an empty slot never blocks upstream slots.
- SKID=0:
  - `in_ready` = slot 0 loads this cycle. This is combinational and may depend on `out_ready`.
- SKID=1:
  - `in_ready = !skid_v` (registered).
  - When slot 0 can load, the source is the skid entry if `skid_v`, else `in_data`.
  - When `in_valid & in_ready` and slot 0 cannot take the data, it is written to the skid entry.
  - The skid entry drains into slot 0 before new input is taken.
- Order is strictly FIFO. No payload is duplicated or dropped except by flush.
- Flush:
  - Every `v[i]` and `skid_v` are 0 on the next edge.
  - An input handshake in the flush cycle is consumed and dropped.
  - An output handshake in the flush cycle completes normally, so downstream owns that data.
  - Flush has priority over every load or advance.
- Reset: all valid bits and payloads are 0. `occupancy` is 0. `out_valid` is 0. `out_data` is 0.
- `in_ready` during and after reset:
  - SKID=1: 1.
  - SKID=0: 1, since slot 0 is empty.
- `occupancy`:
  - Updated registered each edge: `+1` on an accepted input, `-1` on an output handshake, unchanged when both occur.
  - It is 0 after flush or reset.
  - It never exceeds DEPTH+SKID.

## Timing
- Latency from an accepted `in_data` to `out_valid` with an empty chain is DEPTH cycles.
- The skid entry adds 0 cycles when it is unused, and 1 cycle for data that passes through it.
- Throughput is one transfer per cycle when `out_ready` is held high.
- `out_valid`, `out_data` and `occupancy` are register outputs.
- SKID=1: `in_ready` is a register output.
- SKID=0: `in_ready` is combinational from `out_ready` and the valid bits, with no path from `in_valid` or `in_data`.
- Full and `out_ready` high:
  - SKID=0: accepts and emits in the same cycle.
  - SKID=1: the same, as long as the skid entry is empty.
- A flush asserted together with `rst` behaves exactly as reset.

## Structure
- The shared core package holds the handshake bundle typedef helper and the occupancy width function `OCC_W(DEPTH,SKID)`.
- One sub-module is natural: `pipe_skid_entry`, a single-entry skid register with valid, clear and payload. It is instantiated only when SKID=1.
- The slot array is a generate loop in the top module.

## Test plan
- **Reset:** DEPTH=3, SKID=0. Hold rst 2 cycles with `in_valid=1`, `in_data=0xAA`. Required: `out_valid=0`, `out_data=0`, `occupancy=0`, `in_ready=1`. Then accept 0xAA. Required: `out_valid` rises exactly 3 edges later with 0xAA.
- **Streaming:** DEPTH=2, `out_ready=1`, inputs 1,2,3…10 back-to-back. Required: outputs 1…10 in order, one per cycle from cycle 2, and `occupancy` is steady at 2.
- **Backpressure and bubble collapse:** DEPTH=3, SKID=0. Send A, idle 1 cycle, send B, with `out_ready=0`. Required: after 4 cycles `occupancy=2` and `in_ready=1`. Send C, then D. Required: `in_ready=0` after C. Release `out_ready`. Required: outputs A, B, C, D.
- **Skid:** DEPTH=2, SKID=1, chain full, drop `out_ready` in the same cycle as accepting X. Required: X is held in skid, `in_ready=0` on the next cycle, `occupancy=3`. After `out_ready=1`, X emerges after the 2 older entries with no loss.
- **Flush:** DEPTH=3, SKID=1, full plus skid. Assert flush with `out_ready=1` and `in_valid=1` (Y). Required: the head word is delivered, Y is dropped, and on the next cycle `out_valid=0`, `occupancy=0`, `in_ready=1`. With CLEAR_PAYLOAD=1, `out_data=0`.
- **Reset mid-stream:** DEPTH=2, SKID=1, occupancy 3. Assert `rst` together with flush. Required: identical to the reset state on the next edge.
